// File: rtl/if_test_pkg.sv
// ============================================================================
// Module   : if_test_pkg
// Purpose  : Shared constants and I/Q point type for the 8-PSK symbol unroller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_test_pkg;

    localparam logic signed [15:0] AMP_DEFAULT  = 16'sd16384;
    localparam logic signed [15:0] DIAG_DEFAULT = 16'sd11585;
    localparam int                 NUM_SEG      = 10;
    localparam int                 SYM_W        = 3;

    typedef struct packed {
        logic signed [15:0] i;
        logic signed [15:0] q;
    } iq_t;

endpackage

`default_nettype wire

// File: rtl/if_test_psk8_mapper.sv
// ============================================================================
// Module   : psk8_mapper
// Purpose  : Combinational 3-bit symbol to 8-PSK I/Q point lookup.
//            Build option GRAY_MAP_EN inserts a Gray decode ahead of the table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module psk8_mapper
    import if_test_pkg::*;
#(
    parameter logic signed [15:0] AMP  = AMP_DEFAULT,
    parameter logic signed [15:0] DIAG = DIAG_DEFAULT
) (
    input  logic [SYM_W-1:0] i_sym,
    output iq_t              o_iq
);

    localparam logic signed [15:0] c_zero     = 16'sd0;
    localparam logic signed [15:0] c_neg_amp  = -AMP;
    localparam logic signed [15:0] c_neg_diag = -DIAG;

    logic [SYM_W-1:0] w_idx;

`ifdef GRAY_MAP_EN
    assign w_idx = i_sym ^ (i_sym >> 1) ^ (i_sym >> 2);
`else
    assign w_idx = i_sym;
`endif

    // Phase index k selects the point at k*45 degrees
    always_comb begin
        o_iq = '{i: c_zero, q: c_zero};
        case (w_idx)
            3'd0:    o_iq = '{i: AMP,        q: c_zero};
            3'd1:    o_iq = '{i: DIAG,       q: DIAG};
            3'd2:    o_iq = '{i: c_zero,     q: AMP};
            3'd3:    o_iq = '{i: c_neg_diag, q: DIAG};
            3'd4:    o_iq = '{i: c_neg_amp,  q: c_zero};
            3'd5:    o_iq = '{i: c_neg_diag, q: c_neg_diag};
            3'd6:    o_iq = '{i: c_zero,     q: c_neg_amp};
            default: o_iq = '{i: DIAG,       q: c_neg_diag};
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/if_test.sv
// ============================================================================
// Module   : if_test
// Purpose  : 8-PSK symbol unroller: one 32-bit word -> ten registered I/Q
//            points per clock. Build option GRAY_MAP_EN selects Gray mapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_test
    import if_test_pkg::*;
#(
    parameter logic signed [15:0] AMP  = AMP_DEFAULT,
    parameter logic signed [15:0] DIAG = DIAG_DEFAULT
) (
    input  logic [31:0] input_bit,
    output logic [31:0] segment_0,
    output logic [31:0] segment_1,
    output logic [31:0] segment_2,
    output logic [31:0] segment_3,
    output logic [31:0] segment_4,
    output logic [31:0] segment_5,
    output logic [31:0] segment_6,
    output logic [31:0] segment_7,
    output logic [31:0] segment_8,
    output logic [31:0] segment_9,
    input  logic        clk,
    input  logic        reset
);

    iq_t         w_iq  [NUM_SEG];
    logic [31:0] r_seg [NUM_SEG];
    logic        w_unused;

    // Top two bits carry no symbol
    assign w_unused = &{1'b0, input_bit[31:30]};

    for (genvar k = 0; k < NUM_SEG; k++) begin : g_map
        psk8_mapper #(
            .AMP  (AMP),
            .DIAG (DIAG)
        ) u_map (
            .i_sym (input_bit[SYM_W*k +: SYM_W]),
            .o_iq  (w_iq[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_SEG; k++) r_seg[k] <= 32'h0000_0000;
        end else begin
            for (int k = 0; k < NUM_SEG; k++) r_seg[k] <= w_iq[k];
        end
    end

    assign segment_0 = r_seg[0];
    assign segment_1 = r_seg[1];
    assign segment_2 = r_seg[2];
    assign segment_3 = r_seg[3];
    assign segment_4 = r_seg[4];
    assign segment_5 = r_seg[5];
    assign segment_6 = r_seg[6];
    assign segment_7 = r_seg[7];
    assign segment_8 = r_seg[8];
    assign segment_9 = r_seg[9];

endmodule

`default_nettype wire

// File: tb/tb_if_test.sv
// ============================================================================
// Module   : tb_if_test
// Purpose  : Directed, table-driven self-checking bench for if_test.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_test;

    typedef struct packed {
        logic [31:0]       din;
        logic [9:0][31:0]  exp;   // exp[k] is segment_k
    } vec_t;

    localparam logic [31:0] P0 = 32'h4000_0000;
    localparam logic [31:0] P1 = 32'h2D41_2D41;
    localparam logic [31:0] P2 = 32'h0000_4000;
    localparam logic [31:0] P3 = 32'hD2BF_2D41;
    localparam logic [31:0] P4 = 32'hC000_0000;
    localparam logic [31:0] P5 = 32'hD2BF_D2BF;
    localparam logic [31:0] P6 = 32'h0000_C000;
    localparam logic [31:0] P7 = 32'h2D41_D2BF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] input_bit;
    logic [31:0] seg [10];

    int n_vec  = 0;
    int n_miss = 0;

    if_test dut (
        .input_bit (input_bit),
        .segment_0 (seg[0]),
        .segment_1 (seg[1]),
        .segment_2 (seg[2]),
        .segment_3 (seg[3]),
        .segment_4 (seg[4]),
        .segment_5 (seg[5]),
        .segment_6 (seg[6]),
        .segment_7 (seg[7]),
        .segment_8 (seg[8]),
        .segment_9 (seg[9]),
        .clk       (clk),
        .reset     (reset)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [9:0][31:0] exp);
        for (int k = 0; k < 10; k++) begin
            n_vec++;
            if (seg[k] !== exp[k]) begin
                n_miss++;
                $display("FAIL %s seg%0d: got %h expected %h", name, k, seg[k], exp[k]);
            end
        end
    endtask

    function automatic logic [9:0][31:0] all_same(input logic [31:0] p);
        logic [9:0][31:0] r;
        for (int k = 0; k < 10; k++) r[k] = p;
        return r;
    endfunction

    vec_t vecs [6];

    initial begin
        vecs[0] = '{din: 32'h0000_0000, exp: all_same(P0)};
`ifdef GRAY_MAP_EN
        vecs[1] = '{din: 32'h3FFF_FFFF, exp: all_same(P5)};
        vecs[2] = '{din: 32'hFFFF_FFFF, exp: all_same(P5)};
        vecs[3] = '{din: 32'h08FA_C688,
                    exp: {P1, P0, P5, P4, P6, P7, P2, P3, P1, P0}};
        vecs[4] = '{din: 32'h2492_4924, exp: all_same(P7)};
        vecs[5] = '{din: 32'h1B6D_B6DB, exp: all_same(P2)};
`else
        vecs[1] = '{din: 32'h3FFF_FFFF, exp: all_same(P7)};
        vecs[2] = '{din: 32'hFFFF_FFFF, exp: all_same(P7)};
        vecs[3] = '{din: 32'h08FA_C688,
                    exp: {P1, P0, P7, P6, P5, P4, P3, P2, P1, P0}};
        vecs[4] = '{din: 32'h2492_4924, exp: all_same(P4)};
        vecs[5] = '{din: 32'h1B6D_B6DB, exp: all_same(P3)};
`endif

        // Reset held two cycles with all-ones data
        reset     = 1'b1;
        input_bit = 32'hFFFF_FFFF;
        tick();
        check_all("reset_c1", all_same(32'h0));
        tick();
        check_all("reset_c2", all_same(32'h0));

        // Zero word, then 19 cycles of hold
        reset     = 1'b0;
        input_bit = 32'h0000_0000;
        tick();
        check_all("zero_first", all_same(P0));
        for (int c = 0; c < 19; c++) begin
            tick();
            check_all("zero_hold", all_same(P0));
        end

        for (int v = 0; v < 6; v++) begin
            input_bit = vecs[v].din;
            tick();
            check_all($sformatf("vec%0d", v), vecs[v].exp);
        end

        // Back-to-back words then a mid-stream reset
        input_bit = 32'h0000_0000;
        tick();
        check_all("b2b_A", all_same(P0));
        input_bit = 32'h2492_4924;
        tick();
`ifdef GRAY_MAP_EN
        check_all("b2b_B", all_same(P7));
`else
        check_all("b2b_B", all_same(P4));
`endif
        reset = 1'b1;
        tick();
        check_all("b2b_reset", all_same(32'h0));

        // First valid output one edge after reset release
        reset     = 1'b0;
        input_bit = 32'h08FA_C688;
        tick();
        check_all("post_reset", vecs[3].exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_test.md
Name: if_test

Overview:
- 8-PSK symbol unroller for the modulation datapath.
- Each clock, one 32-bit input word is split into ten 3-bit symbols.
- Each symbol is mapped to a packed I/Q constellation point, and all ten points are presented in parallel on ten registered 32-bit segment outputs.
- Sits between the bit source and the DAC/pulse-shaping stage.

Parameters:
- AMP, 16384, axis amplitude (signed 16-bit, Q1.14 full scale = 1.0).
- DIAG, 11585, diagonal component, round(AMP*cos 45°).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- input_bit  input  32  data word; bits [29:0] used, [31:30] ignored.
- segment_0 .. segment_9  output  32 each  mapped symbol k = {I[15:0], Q[15:0]}, two's complement.
- Positional port order is fixed: input_bit, segment_0 … segment_9, clk, reset.

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset). No other clock or asynchronous logic.
- Reset: on a rising clk edge with reset=1, all segment_k = 32'h0000_0000. Reset overrides data on that edge. Reset asserted mid-stream clears outputs on the next edge; the first valid output appears one edge after reset deasserts.
- Symbol extraction: sym_k = input_bit[3k+2:3k], k = 0..9. Bits 31:30 have no effect.
- Natural mapping, phase = sym*45°, giving {I, Q}:
  - 0: {AMP, 0}
  - 1: {DIAG, DIAG}
  - 2: {0, AMP}
  - 3: {-DIAG, DIAG}
  - 4: {-AMP, 0}
  - 5: {-DIAG, -DIAG}
  - 6: {0, -AMP}
  - 7: {DIAG, -DIAG}
- Negation is 16-bit two's complement, e.g. -16384 = 16'hC000 and -11585 = 16'hD2BF.
- Latency: exactly 1 cycle. segment_k after edge n reflects input_bit sampled at edge n. No handshake; a new word is accepted every cycle.
- Outputs are held constant while input is constant. No internal state other than the ten output registers.
- No X propagation: if input_bit is X, outputs may be X; after valid input, outputs are defined next cycle.

Optional Feature:
- GRAY_MAP_EN
  - Defined: sym_k is Gray-decoded before the table (idx = sym^(sym>>1)^(sym>>2)), so adjacent phases differ by one bit. Examples: 3'b011 → idx 2 → {0, AMP}; 3'b100 → idx 7.
  - Undefined: natural mapping as above. Latency and reset behaviour are identical in both cases.

Decomposition:
- Shared package if_test_pkg holds:
  - constants AMP_DEFAULT, DIAG_DEFAULT, NUM_SEG=10, SYM_W=3;
  - typedef iq_t (packed struct of signed I and signed Q, 16 bits each).
- One combinational sub-module psk8_mapper (3-bit symbol in, iq_t out, contains the if/case LUT and the optional Gray decode), instantiated ten times via generate.
- The top level holds only the registers and reset.

Test Plan:
- Reset held 2 cycles with input 32'hFFFF_FFFF → all segments 32'h0000_0000 throughout reset.
- input_bit=32'h0000_0000 after reset → one cycle later every segment = 32'h4000_0000; stable for 19 consecutive cycles.
- input_bit=32'h3FFF_FFFF (all sym=7) → every segment = 32'h2D41_D2BF; repeat with 32'hFFFF_FFFF → identical (bits 31:30 ignored).
- input_bit with sym_k=k mod 8 (sym0..9 = 0,1,2,3,4,5,6,7,0,1):
  - segment_0=4000_0000, segment_1=2D41_2D41, segment_2=0000_4000, segment_3=D2BF_2D41, segment_4=C000_0000;
  - segment_5=D2BF_D2BF, segment_6=0000_C000, segment_7=2D41_D2BF, segment_8=4000_0000, segment_9=2D41_2D41.
- Back-to-back words A=0, B=32'h2492_4924 (all sym=4), then reset on the third edge → outputs 4000_0000, then C000_0000, then 0.
- With GRAY_MAP_EN, all sym=3'b011 → every segment = 32'h0000_4000.
